// File: rtl/rom_seq_ctrl.sv
// ROM address sequencer: auto-steps every CNT_MAX+1 cycles (AUTO) or freezes (HOLD), with manual
// up/down keys and a shift-token read pipeline. Define ROM_SEQ_PINGPONG_EN for bouncing auto-steps.
module rom_seq_ctrl #(
    parameter int          ADDR_W  = 8,
    parameter int          DEPTH   = 256,
    parameter int          DATA_W  = 8,
    parameter logic [23:0] CNT_MAX = 24'd9_999_999,
    parameter int          RD_LAT  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_hold,
    input  logic              key_up,
    input  logic              key_dn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              hold_mode
);

    typedef enum logic {ST_AUTO = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [23:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] tok_q, tok_d;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              hold_q;
    logic              step_up_s, step_dn_s, manual_s, auto_s;
`ifdef ROM_SEQ_PINGPONG_EN
    logic              dir_up_q, dir_up_d;
`endif

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? {ADDR_W{1'b0}} : a + ONE;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
        return (a == {ADDR_W{1'b0}}) ? LAST : a - ONE;
    endfunction

    // Next-state: mode toggle, interval counter, address stepping and token launch
    always_comb begin
        step_up_s = key_up & ~key_dn;
        step_dn_s = key_dn & ~key_up;
        manual_s  = step_up_s | step_dn_s;
        // a manual step in the same cycle swallows the auto-step
        auto_s    = (state_q == ST_AUTO) && (cnt_q == CNT_MAX) && !manual_s;

        if (key_hold) begin
            state_d = (state_q == ST_AUTO) ? ST_HOLD : ST_AUTO;
        end else begin
            state_d = state_q;
        end

        if ((state_q == ST_HOLD) || (state_d == ST_HOLD) || manual_s || (cnt_q == CNT_MAX)) begin
            cnt_d = 24'd0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        addr_d = addr_q;
`ifdef ROM_SEQ_PINGPONG_EN
        dir_up_d = dir_up_q;
`endif
        if (step_up_s) begin
            addr_d = addr_inc(addr_q);
        end else if (step_dn_s) begin
            addr_d = addr_dec(addr_q);
        end else if (auto_s) begin
`ifdef ROM_SEQ_PINGPONG_EN
            // bounce at either end without repeating the end address
            if (dir_up_q) begin
                if (addr_q == LAST) begin
                    addr_d   = addr_q - ONE;
                    dir_up_d = 1'b0;
                end else begin
                    addr_d = addr_q + ONE;
                end
            end else begin
                if (addr_q == {ADDR_W{1'b0}}) begin
                    addr_d   = ONE;
                    dir_up_d = 1'b1;
                end else begin
                    addr_d = addr_q - ONE;
                end
            end
`else
            addr_d = addr_inc(addr_q);
`endif
        end else begin
            addr_d = addr_q;
        end

        tok_d = RD_LAT'({tok_q, (addr_d != addr_q)});
    end

    // State, counter, address, token pipeline and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_AUTO;
            cnt_q    <= 24'd0;
            addr_q   <= {ADDR_W{1'b0}};
            tok_q    <= {RD_LAT{1'b0}};
            dout_q   <= {DATA_W{1'b0}};
            vld_q    <= 1'b0;
            hold_q   <= 1'b0;
`ifdef ROM_SEQ_PINGPONG_EN
            dir_up_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            tok_q    <= tok_d;
            vld_q    <= tok_q[RD_LAT-1];
            hold_q   <= (state_d == ST_HOLD);
`ifdef ROM_SEQ_PINGPONG_EN
            dir_up_q <= dir_up_d;
`endif
            if (tok_q[RD_LAT-1]) begin
                dout_q <= rom_rd_data;
            end else begin
                dout_q <= dout_q;
            end
        end
    end

    assign rom_addr  = addr_q;
    assign data_out  = dout_q;
    assign data_vld  = vld_q;
    assign hold_mode = hold_q;

endmodule
